// File: rtl/cnna_arith_pkg.sv
// cnna_arith_pkg: shared arithmetic helpers for the CNN accelerator multiply datapath
`define CNNA_CHECK_ACC_WIDTH(acc_w, p_w) \
    if ((acc_w) < (p_w)) begin : g_acc_width_check \
        $error("ACC_WIDTH must be >= DIN0_WIDTH+DIN1_WIDTH"); \
    end

package cnna_arith_pkg;
    typedef enum logic {ACC_IDLE, ACC_OPEN} acc_state_t;

    function automatic int prod_width(input int w0, input int w1);
        return w0 + w1;
    endfunction

    function automatic bit res_signed(input int s0, input int s1);
        return (s0 != 0) || (s1 != 0);
    endfunction

    function automatic logic [63:0] ext_operand(input logic [63:0] v, input int width, input bit sgn);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = (i < width) ? v[i] : (sgn & v[width-1]);
        return r;
    endfunction
endpackage

// File: rtl/cnna_mul_acc_pipe_if.sv
// cnna_mul_acc_pipe_if: valid/ready operand and result bus of the multiply-accumulate unit
interface cnna_mul_acc_pipe_if #(
    parameter int DIN0_WIDTH = 13,
    parameter int DIN1_WIDTH = 22,
    parameter int ACC_WIDTH  = 48
);
    logic                  in_valid, in_ready, acc_en, acc_last;
    logic [DIN0_WIDTH-1:0] din0;
    logic [DIN1_WIDTH-1:0] din1;
    logic                  out_valid, out_ready, dout_ovf;
    logic [ACC_WIDTH-1:0]  dout;

    modport master(output in_valid, din0, din1, acc_en, acc_last, out_ready,
                   input in_ready, out_valid, dout, dout_ovf);
    modport slave(input in_valid, din0, din1, acc_en, acc_last, out_ready,
                  output in_ready, out_valid, dout, dout_ovf);
endinterface

// File: rtl/cnna_mul_pipe.sv
// cnna_mul_pipe: NUM_STAGE-deep registered signed multiplier with valid/tag chain and global enable
module cnna_mul_pipe import cnna_arith_pkg::*; #(
    parameter int DIN0_WIDTH  = 13,
    parameter int DIN1_WIDTH  = 22,
    parameter int NUM_STAGE   = 3,
    parameter int DIN0_SIGNED = 0,
    parameter int DIN1_SIGNED = 0,
    parameter int TAG_WIDTH   = 2,
    localparam int PW = prod_width(DIN0_WIDTH, DIN1_WIDTH)
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    input  logic [TAG_WIDTH-1:0]  tag_in,
    output logic                  p_valid,
    output logic [PW-1:0]         p,
    output logic [TAG_WIDTH-1:0]  tag_out
);
    logic [63:0]          a_w, b_w;
    logic [NUM_STAGE-1:0] vld_q;
    logic [PW-1:0]        prod_q [NUM_STAGE];
    logic [TAG_WIDTH-1:0] tag_q  [NUM_STAGE];

    assign a_w = ext_operand(64'(din0), DIN0_WIDTH, DIN0_SIGNED != 0);
    assign b_w = ext_operand(64'(din1), DIN1_WIDTH, DIN1_SIGNED != 0);

    always_ff @(posedge ap_clk or negedge ap_rst_n)
        if (!ap_rst_n) vld_q <= '0;
        else if (ce) begin
            vld_q[0] <= in_valid;
            for (int i = 1; i < NUM_STAGE; i++) vld_q[i] <= vld_q[i-1];
        end

    // Datapath registers carry no reset so they can be absorbed into DSP pipeline registers
    always_ff @(posedge ap_clk)
        if (ce) begin
            prod_q[0] <= PW'(a_w * b_w);
            tag_q[0]  <= tag_in;
            for (int i = 1; i < NUM_STAGE; i++) begin
                prod_q[i] <= prod_q[i-1];
                tag_q[i]  <= tag_q[i-1];
            end
        end

    assign p_valid = vld_q[NUM_STAGE-1];
    assign p       = prod_q[NUM_STAGE-1];
    assign tag_out = tag_q[NUM_STAGE-1];
endmodule

// File: rtl/cnna_mul_acc_pipe.sv
// cnna_mul_acc_pipe: pipelined multiply / dot-product accumulate with valid/ready flow control
module cnna_mul_acc_pipe import cnna_arith_pkg::*; #(
    parameter int DIN0_WIDTH  = 13,
    parameter int DIN1_WIDTH  = 22,
    parameter int ACC_WIDTH   = 48,
    parameter int NUM_STAGE   = 3,
    parameter int DIN0_SIGNED = 0,
    parameter int DIN1_SIGNED = 0
) (
    input logic               ap_clk,
    input logic               ap_rst_n,
    cnna_mul_acc_pipe_if.slave bus
);
    localparam int PW = prod_width(DIN0_WIDTH, DIN1_WIDTH);
    localparam bit RS = res_signed(DIN0_SIGNED, DIN1_SIGNED);

    `CNNA_CHECK_ACC_WIDTH(ACC_WIDTH, PW)

    acc_state_t           st_q, st_d;
    logic                 ce, run_q, p_valid, carry, ovf_add, ovf_q, ovf_d, load, load_ovf;
    logic                 out_valid_q, dout_ovf_q;
    logic [1:0]           tag;
    logic [PW-1:0]        p;
    logic [ACC_WIDTH-1:0] px, base, sum, acc_q, acc_d, dout_d, dout_q;

    assign ce           = !(out_valid_q && !bus.out_ready);
    assign bus.in_ready = ce && run_q;

    cnna_mul_pipe #(
        .DIN0_WIDTH(DIN0_WIDTH), .DIN1_WIDTH(DIN1_WIDTH), .NUM_STAGE(NUM_STAGE),
        .DIN0_SIGNED(DIN0_SIGNED), .DIN1_SIGNED(DIN1_SIGNED), .TAG_WIDTH(2)
    ) u_mul (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .ce       (ce),
        .in_valid (bus.in_valid && bus.in_ready),
        .din0     (bus.din0),
        .din1     (bus.din1),
        .tag_in   ({bus.acc_en, bus.acc_last}),
        .p_valid  (p_valid),
        .p        (p),
        .tag_out  (tag)
    );

    assign px   = RS ? ACC_WIDTH'($signed(p)) : ACC_WIDTH'(p);
    assign base = (st_q == ACC_OPEN) ? acc_q : '0;
    assign {carry, sum} = {1'b0, base} + {1'b0, px};
    // Signed wrap shows as equal-sign operands producing a result of the other sign
    assign ovf_add = RS ? (base[ACC_WIDTH-1] == px[ACC_WIDTH-1]) && (sum[ACC_WIDTH-1] != base[ACC_WIDTH-1]) : carry;

    always_comb begin
        st_d     = st_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        load     = 1'b0;
        dout_d   = px;
        load_ovf = 1'b0;
        if (ce && p_valid) begin
            load     = !tag[1] || tag[0];
            dout_d   = tag[1] ? sum : px;
            load_ovf = tag[1] && (ovf_q || ovf_add);
            st_d     = (tag[1] && !tag[0]) ? ACC_OPEN : ACC_IDLE;
            acc_d    = (tag[1] && !tag[0]) ? sum : '0;
            ovf_d    = tag[1] && !tag[0] && (ovf_q || ovf_add);
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n)
        if (!ap_rst_n) begin
            st_q  <= ACC_IDLE;
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            st_q  <= st_d;
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end

    always_ff @(posedge ap_clk or negedge ap_rst_n)
        if (!ap_rst_n) begin
            run_q       <= 1'b0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            dout_ovf_q  <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (ce) begin
                out_valid_q <= load;
                if (load) begin
                    dout_q     <= dout_d;
                    dout_ovf_q <= load_ovf;
                end
            end
        end

    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
    assign bus.dout_ovf  = dout_ovf_q;
endmodule

// File: tb/tb_cnna_mul_acc_pipe.sv
// tb_cnna_mul_acc_pipe: directed self-checking bench over default, signed and narrow-accumulator builds
module tb_cnna_mul_acc_pipe;
    logic        ap_clk, ap_rst_n;
    logic        iv, ord, en, last;
    logic [12:0] a;
    logic [21:0] b;
    int          sel;
    int          checks, failures;
    logic        cur_rdy, cur_ov, cur_ovf;
    logic [63:0] cur_dout;
    logic [47:0] q[$];

    cnna_mul_acc_pipe_if #(.DIN0_WIDTH(13), .DIN1_WIDTH(22), .ACC_WIDTH(48)) bd();
    cnna_mul_acc_pipe_if #(.DIN0_WIDTH(13), .DIN1_WIDTH(22), .ACC_WIDTH(48)) bs();
    cnna_mul_acc_pipe_if #(.DIN0_WIDTH(13), .DIN1_WIDTH(22), .ACC_WIDTH(36)) bw();

    cnna_mul_acc_pipe u_def (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(bd));
    cnna_mul_acc_pipe #(.DIN1_SIGNED(1)) u_sgn (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(bs));
    cnna_mul_acc_pipe #(.ACC_WIDTH(36)) u_w36 (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(bw));

    assign bd.in_valid = iv && sel == 0;
    assign bs.in_valid = iv && sel == 1;
    assign bw.in_valid = iv && sel == 2;
    assign bd.din0 = a;  assign bs.din0 = a;  assign bw.din0 = a;
    assign bd.din1 = b;  assign bs.din1 = b;  assign bw.din1 = b;
    assign bd.acc_en = en;    assign bs.acc_en = en;    assign bw.acc_en = en;
    assign bd.acc_last = last; assign bs.acc_last = last; assign bw.acc_last = last;
    assign bd.out_ready = ord; assign bs.out_ready = ord; assign bw.out_ready = ord;

    assign cur_rdy  = sel == 0 ? bd.in_ready  : sel == 1 ? bs.in_ready  : bw.in_ready;
    assign cur_ov   = sel == 0 ? bd.out_valid : sel == 1 ? bs.out_valid : bw.out_valid;
    assign cur_ovf  = sel == 0 ? bd.dout_ovf  : sel == 1 ? bs.dout_ovf  : bw.dout_ovf;
    assign cur_dout = sel == 0 ? 64'(bd.dout) : sel == 1 ? 64'(bs.dout) : 64'(bw.dout);

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) if (ap_rst_n && bd.out_valid && bd.out_ready) q.push_back(bd.dout);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic [12:0] da, input logic [21:0] db, input logic de, input logic dl);
        int   k = 0;
        logic ok;
        a = da; b = db; en = de; last = dl; iv = 1'b1;
        do begin
            @(negedge ap_clk);
            ok = cur_rdy;
            @(posedge ap_clk);
            #1;
            k++;
        end while (!ok && k < 40);
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
        iv = 1'b0;
    endtask

    task automatic wait_out(output int lat, output logic [63:0] d, output logic o);
        lat = -1; d = '0; o = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge ap_clk);
            #1;
            if (cur_ov) begin
                lat = c; d = cur_dout; o = cur_ovf;
                break;
            end
        end
    endtask

    initial begin
        int          lat;
        logic [63:0] d;
        logic        o;
        checks = 0; failures = 0;
        sel = 0; iv = 1'b0; ord = 1'b1; en = 1'b0; last = 1'b0; a = '0; b = '0;
        ap_rst_n = 1'b0;
        repeat (3) @(posedge ap_clk);
        #1;
        chk("rst_out_valid", cur_ov, 0);
        chk("rst_dout", cur_dout, 0);
        chk("rst_ovf", cur_ovf, 0);
        chk("rst_in_ready", cur_rdy, 0);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        chk("post_rst_in_ready", cur_rdy, 1);

        // max unsigned pass-through: output on the third edge after the accept edge
        q.delete();
        send(13'd8191, 22'd4194303, 1'b0, 1'b0);
        wait_out(lat, d, o);
        chk("pt_latency", 64'(lat), 3);
        chk("pt_dout", d, 64'd34355535873);
        chk("pt_ovf", o, 0);
        @(posedge ap_clk);
        #1;
        chk("pt_single_pulse", cur_ov, 0);

        q.delete();
        send(13'd2, 22'd3, 1'b1, 1'b0);
        send(13'd4, 22'd5, 1'b1, 1'b0);
        send(13'd6, 22'd7, 1'b1, 1'b1);
        wait_out(lat, d, o);
        chk("acc_latency", 64'(lat), 3);
        chk("acc_dout", d, 64'd68);
        chk("acc_ovf", o, 0);
        repeat (3) @(posedge ap_clk);
        #1;
        chk("acc_one_output", 64'(q.size()), 1);

        // pass-through beat inside an open group drops the partial sum
        q.delete();
        send(13'd2, 22'd3, 1'b1, 1'b0);
        send(13'd4, 22'd5, 1'b0, 1'b0);
        send(13'd1, 22'd1, 1'b1, 1'b1);
        repeat (8) @(posedge ap_clk);
        #1;
        chk("perr_count", 64'(q.size()), 2);
        chk("perr_pass", q.size() > 0 ? 64'(q[0]) : '1, 64'd20);
        chk("perr_group", q.size() > 1 ? 64'(q[1]) : '1, 64'd1);

        q.delete();
        fork
            begin
                for (int i = 0; i < 10; i++) send(13'(i), 22'd1, 1'b0, 1'b0);
            end
            begin
                repeat (6) @(posedge ap_clk);
                #1;
                ord = 1'b0;
                for (int j = 0; j < 5; j++) begin
                    @(posedge ap_clk);
                    #1;
                    chk($sformatf("stall_in_ready_%0d", j), cur_rdy, 0);
                end
                ord = 1'b1;
            end
        join
        for (int k = 0; k < 60 && q.size() < 10; k++) @(posedge ap_clk);
        #1;
        chk("stream_count", 64'(q.size()), 10);
        for (int i = 0; i < 10; i++) chk($sformatf("stream_%0d", i), q.size() > i ? 64'(q[i]) : '1, 64'(i));

        sel = 1;
        send(13'd3, 22'h3FFFFF, 1'b0, 1'b0);
        wait_out(lat, d, o);
        chk("sgn_dout", d, 64'h0000_FFFF_FFFF_FFFD);
        chk("sgn_ovf", o, 0);

        sel = 2;
        send(13'd8191, 22'd4194303, 1'b1, 1'b0);
        send(13'd8191, 22'd4194303, 1'b1, 1'b0);
        send(13'd8191, 22'd4194303, 1'b1, 1'b1);
        wait_out(lat, d, o);
        chk("w36_dout", d, 64'd34347130883);
        chk("w36_ovf", o, 1);
        send(13'd1, 22'd1, 1'b1, 1'b1);
        wait_out(lat, d, o);
        chk("w36_next_dout", d, 64'd1);
        chk("w36_next_ovf", o, 0);

        // reset lands between clock edges with a group open and two beats in flight
        sel = 0;
        send(13'd2, 22'd2, 1'b1, 1'b0);
        send(13'd3, 22'd3, 1'b1, 1'b0);
        repeat (5) @(posedge ap_clk);
        #1;
        send(13'd1, 22'd1, 1'b1, 1'b0);
        send(13'd1, 22'd1, 1'b1, 1'b0);
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", cur_ov, 0);
        chk("async_rst_dout", cur_dout, 0);
        chk("async_rst_in_ready", cur_rdy, 0);
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        q.delete();
        send(13'd5, 22'd5, 1'b1, 1'b1);
        wait_out(lat, d, o);
        chk("after_rst_dout", d, 64'd25);
        chk("after_rst_ovf", o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cnna_mul_acc_pipe.md
Name: cnna_mul_acc_pipe

Overview:
- Parametrised, pipelined multiply / multiply-accumulate unit for the CNN accelerator datapath.
- Successor to the fixed-width, single-cycle DSP multiplier wrappers.
- Adds per-operand signedness, configurable latency, valid/ready flow control with backpressure, and an accumulate mode that sums a dot-product group and emits one result per group.

Parameters:
- DIN0_WIDTH, 13, width of din0.
- DIN1_WIDTH, 22, width of din1.
- ACC_WIDTH, 48, accumulator/output width; must be >= DIN0_WIDTH+DIN1_WIDTH (elaboration error otherwise).
- NUM_STAGE, 3, multiplier pipeline stages (>=1).
- DIN0_SIGNED, 0, 1 = din0 is two's complement.
- DIN1_SIGNED, 0, 1 = din1 is two's complement.

Ports:
- ap_clk  in  1  clock; all state on rising edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- din0  in  DIN0_WIDTH  operand A.
- din1  in  DIN1_WIDTH  operand B.
- acc_en  in  1  beat belongs to an accumulation group.
- acc_last  in  1  last beat of group; ignored when acc_en=0.
- out_valid  out  1  dout valid.
- out_ready  in  1  downstream accepts dout.
- dout  out  ACC_WIDTH  product or group sum.
- dout_ovf  out  1  result wrapped at ACC_WIDTH.

Behaviour:
- Reset (async assert, sync-safe deassert): all stage valid bits 0, accumulator 0, ovf flag 0. Outputs: out_valid=0, dout=0, dout_ovf=0. in_ready=1 one cycle after release.
- Accept: beat accepted when in_valid && in_ready.
- Global enable: ce = !(out_valid && !out_ready). in_ready = ce. All stages, accumulator and output register hold when ce=0. No beat lost or duplicated; order preserved.
- Signedness:
  - Each operand is sign- or zero-extended by one bit and multiplied signed.
  - Product P = DIN0_WIDTH+DIN1_WIDTH bits.
  - RES_SIGNED = DIN0_SIGNED|DIN1_SIGNED. P is sign-extended to ACC_WIDTH if RES_SIGNED, else zero-extended.
- Latency: product valid NUM_STAGE cycles after accept. Output register loads one cycle later, so first out_valid = NUM_STAGE+1 cycles after accept when unstalled. Throughput 1 beat/cycle.
- Pass-through (acc_en=0): dout = extended product, dout_ovf=0, one output per input.
- Accumulate (acc_en=1):
  - Accumulator state is OPEN/IDLE.
  - IDLE + acc beat: acc = product; go OPEN.
  - OPEN + acc beat: acc += product, wrapping modulo 2^ACC_WIDTH.
  - Overflow (unsigned carry out, or signed operand-sign vs result-sign mismatch) sets sticky ovf.
  - Beat with acc_last: emit acc (incl. that beat) with dout_ovf=ovf; clear acc/ovf; go IDLE.
  - Single-beat group (acc_last on first beat) emits that product.
  - Non-last beats produce no output.
- Protocol error, acc_en=0 beat while OPEN: partial group discarded (acc/ovf cleared, IDLE); the pass-through product is emitted normally.
- Simultaneous events: output handshake and new arrival at the output register in the same cycle → register reloads, out_valid stays 1.
- Reset mid-operation: in-flight beats and partial group dropped; out_valid falls asynchronously.

Decomposition:
- Shared package cnna_arith_pkg:
  - function ext_operand(width, signed) for operand extension;
  - localparam formulas for P width and RES_SIGNED;
  - a check macro for ACC_WIDTH >= P.
- Sub-module cnna_mul_pipe: NUM_STAGE-deep registered signed multiplier with valid shift chain and ce input. Retimable into DSP48 registers.
- Top holds the accumulator FSM and output register.

Test Plan:
- Defaults, pass-through, din0=8191, din1=4194303, out_ready=1 → dout=34355535873 at accept+4 cycles, dout_ovf=0.
- Accumulate group (2,3),(4,5),(6,7,last) back-to-back → single out_valid pulse, dout=68, 4 cycles after third accept; no earlier outputs.
- DIN1_SIGNED=1, din0=3, din1=22'h3FFFFF → dout=48'hFFFF_FFFF_FFFD.
- ACC_WIDTH=36, unsigned, accumulate (8191,4194303)×3 then last → dout = (3×34355535873) mod 2^36, dout_ovf=1. Next group (1,1,last) → dout=1, dout_ovf=0.
- Stream 10 pass-through beats din0=i, din1=1 with out_ready low for 5 cycles mid-stream → in_ready low while stalled, outputs 0..9 in order, none lost.
- Assert ap_rst_n low with a 2-beat open group and 2 beats in flight → out_valid=0 immediately. After release, group (5,5,last) → dout=25.
